ov5640_dvp_pattern_tx: RTL and testbench
========================================

Name: ov5640_dvp_pattern_tx

Overview:
- DVP transmitter that emulates the OV5640 RGB565 parallel output: drives cam_vsync/cam_href/cam_data on cam_pclk.
- Feeds the capture path in simulation and on hardware loopback, so stitching and UDP paths can be exercised without a sensor.
- Generates test patterns internally.
- Byte order and sync polarity match the sensor: vsync pulse active-high, href high during active bytes, high byte first.

Parameters:
H_ACTIVE, 640, active pixels per line; must be a multiple of 8 and at least 8
V_ACTIVE, 480, active lines per frame; at least 1
H_BLANK, 64, pclk cycles with href low after each line; at least 1
VSYNC_W, 16, pclk cycles cam_vsync is high; at least 1
V_BACK, 32, pclk cycles after vsync falls before the first line; at least 1
V_FRONT, 32, pclk cycles after the last line's blank before the next vsync; at least 1
SOLID_RGB, 16'hF800, RGB565 value used by pattern 0

Ports:
cam_pclk  input  1  pixel byte clock
rst_n  input  1  reset, asynchronous, active-low
enable  input  1  run frames continuously while high
pattern_sel  input  2  0 solid, 1 colour bars, 2 ramp, 3 checker
cam_vsync  output  1  frame sync, active-high pulse
cam_href  output  1  high during active bytes of a line
cam_data  output  8  pixel byte; 0 whenever href is low
frame_start  output  1  one-cycle pulse on the first VSYNC cycle of a frame
frame_cnt  output  16  frames started since reset; wraps at 16'hFFFF to 0
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: the interface is decided as rst_n, asynchronous, active-low, with clock cam_pclk. All outputs and counters clear to 0 and the FSM goes to IDLE.
  - rst_n falling mid-frame forces all outputs to 0 immediately.
  - After release, the first frame starts no earlier than the second cam_pclk edge.
- All outputs are registered; no combinational paths from inputs to outputs.
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT.
  - IDLE: if enable is 1, go to VSYNC next cycle, latch pattern_sel, pulse frame_start, increment frame_cnt.
  - VSYNC: cam_vsync=1 for exactly VSYNC_W cycles, then VBACK.
  - VBACK: V_BACK cycles, then ACTIVE with line y=0.
  - ACTIVE: cam_href=1 for exactly 2*H_ACTIVE cycles. The byte phase toggles every cycle; even phase carries pix[15:8], odd phase carries pix[7:0]. x increments after each odd byte. Then HBLANK.
  - HBLANK: H_BLANK cycles. Then, if y < V_ACTIVE-1, increment y and go to ACTIVE; otherwise go to VFRONT.
  - VFRONT: V_FRONT cycles. Then, if enable is 1, go to VSYNC (same actions as leaving IDLE); otherwise go to IDLE.
- Frame period = VSYNC_W + V_BACK + V_ACTIVE*(2*H_ACTIVE + H_BLANK) + V_FRONT cycles.
- enable is sampled only at IDLE and at the end of VFRONT. Deassertion mid-frame completes the current frame.
- pattern_sel is latched only at frame start; changes mid-frame have no effect until the next frame.
- Pattern pix(x,y):
  - 0: SOLID_RGB.
  - 1: eight bars, bar index = x / (H_ACTIVE/8). Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 2: (x + y) truncated to 16 bits.
  - 3: FFFF when x[4] XOR y[4] is 1, else 0000.
- x, y: 12-bit counters; both are 0 at the start of each frame, and x is 0 at the start of each line.

Optional Feature:
- Macro DVP_TX_FRAME_TAG_EN.
- Defined: pixel (0,0) of each frame is replaced by the value of frame_cnt after its increment for that frame; all other pixels are unchanged. Lets downstream checks detect dropped or repeated frames.
- Undefined: every pixel follows the pattern; no extra logic.

Test Plan:
- Params H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, VSYNC_W=3, V_BACK=2, V_FRONT=2; enable=1 held -> frame_start pulses every 87 cycles; vsync high for 3 cycles; 4 href pulses of 16 cycles, each followed by 4 low cycles.
- Same params, pattern 1 -> line bytes are FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00; cam_data=0 during HBLANK.
- Pattern 2 -> line y=3 carries pixels 0003..000A; the byte immediately after each href rise is the high byte, 00.
- enable dropped mid-line 2 -> frame completes all 4 lines and VFRONT, then IDLE with busy=0; frame_cnt=1.
- rst_n pulsed low mid-ACTIVE -> vsync, href, data and frame_cnt read 0 within the same cycle; the first frame after release has frame_cnt=1.
- With DVP_TX_FRAME_TAG_EN defined, pattern 0 -> first two bytes of frame 3 are 00 03; remaining pixels are F800.

Source files
------------

// File: rtl/ov5640_dvp_pattern_tx.sv
// rtl/ov5640_dvp_pattern_tx.sv - OV5640-style RGB565 DVP transmitter with built-in test patterns.
// Optional: define DVP_TX_FRAME_TAG_EN to replace pixel (0,0) of each frame with frame_cnt.
module ov5640_dvp_pattern_tx #(
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter int          H_BLANK   = 64,
  parameter int          VSYNC_W   = 16,
  parameter int          V_BACK    = 32,
  parameter int          V_FRONT   = 32,
  parameter logic [15:0] SOLID_RGB = 16'hF800
) (
  input  logic        cam_pclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_start,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBACK  = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_HBLANK = 3'd4;
  localparam logic [2:0] S_VFRONT = 3'd5;

  localparam logic [15:0] VS_LAST  = 16'(VSYNC_W - 1);
  localparam logic [15:0] VB_LAST  = 16'(V_BACK - 1);
  localparam logic [15:0] ACT_LAST = 16'(2 * H_ACTIVE - 1);
  localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);
  localparam logic [15:0] VF_LAST  = 16'(V_FRONT - 1);
  localparam logic [11:0] Y_LAST   = 12'(V_ACTIVE - 1);
  localparam logic [11:0] BAR_W    = 12'(H_ACTIVE / 8);

  logic [2:0]  state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [11:0] x, x_n, y, y_n;
  logic        ph, ph_n;
  logic [1:0]  pat, pat_n;
  logic [15:0] fcnt_n;
  logic        start_n;
  logic        armed;
  logic        go;
  logic [11:0] bar_idx;
  logic [15:0] pix;

  // A new frame begins from IDLE (once a cycle has passed since reset) or back-to-back after VFRONT.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    x_n     = x;
    y_n     = y;
    ph_n    = ph;
    pat_n   = pat;
    fcnt_n  = frame_cnt;
    start_n = 1'b0;
    go      = 1'b0;
    case (state)
      S_IDLE: go = enable && armed;
      S_VSYNC: begin
        if (cnt == VS_LAST) begin
          state_n = S_VBACK;
          cnt_n   = 16'd0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_VBACK: begin
        if (cnt == VB_LAST) begin
          state_n = S_ACTIVE;
          cnt_n   = 16'd0;
          x_n     = 12'd0;
          y_n     = 12'd0;
          ph_n    = 1'b0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_ACTIVE: begin
        if (cnt == ACT_LAST) begin
          state_n = S_HBLANK;
          cnt_n   = 16'd0;
        end else begin
          cnt_n = cnt + 16'd1;
          ph_n  = ~ph;
          if (ph) x_n = x + 12'd1;
        end
      end
      S_HBLANK: begin
        if (cnt == HB_LAST) begin
          cnt_n = 16'd0;
          if (y < Y_LAST) begin
            state_n = S_ACTIVE;
            y_n     = y + 12'd1;
            x_n     = 12'd0;
            ph_n    = 1'b0;
          end else begin
            state_n = S_VFRONT;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_VFRONT: begin
        if (cnt == VF_LAST) begin
          cnt_n = 16'd0;
          if (enable) go = 1'b1;
          else        state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (go) begin
      state_n = S_VSYNC;
      cnt_n   = 16'd0;
      pat_n   = pattern_sel;
      start_n = 1'b1;
      fcnt_n  = frame_cnt + 16'd1;
    end
  end

  // Pixel for the byte about to be presented, so cam_data can be registered alongside href.
  always_comb begin
    bar_idx = x_n / BAR_W;
    pix     = 16'h0000;
    case (pat_n)
      2'd0: pix = SOLID_RGB;
      2'd1: begin
        case (bar_idx)
          12'd0:   pix = 16'hFFFF;
          12'd1:   pix = 16'hFFE0;
          12'd2:   pix = 16'h07FF;
          12'd3:   pix = 16'h07E0;
          12'd4:   pix = 16'hF81F;
          12'd5:   pix = 16'hF800;
          12'd6:   pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'd2:    pix = {4'd0, x_n} + {4'd0, y_n};
      default: pix = (x_n[4] ^ y_n[4]) ? 16'hFFFF : 16'h0000;
    endcase
`ifdef DVP_TX_FRAME_TAG_EN
    if (x_n == 12'd0 && y_n == 12'd0) pix = fcnt_n;
`endif
  end

  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= 16'd0;
      x           <= 12'd0;
      y           <= 12'd0;
      ph          <= 1'b0;
      pat         <= 2'd0;
      armed       <= 1'b0;
      cam_vsync   <= 1'b0;
      cam_href    <= 1'b0;
      cam_data    <= 8'd0;
      frame_start <= 1'b0;
      frame_cnt   <= 16'd0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      x           <= x_n;
      y           <= y_n;
      ph          <= ph_n;
      pat         <= pat_n;
      armed       <= 1'b1;
      cam_vsync   <= (state_n == S_VSYNC);
      cam_href    <= (state_n == S_ACTIVE);
      cam_data    <= (state_n == S_ACTIVE) ? (ph_n ? pix[7:0] : pix[15:8]) : 8'd0;
      frame_start <= start_n;
      frame_cnt   <= fcnt_n;
      busy        <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_ov5640_dvp_pattern_tx.sv
// tb/tb_ov5640_dvp_pattern_tx.sv - self-checking bench for ov5640_dvp_pattern_tx.
// Expected streams come from a per-cycle arithmetic frame model; pixels also checked against a constant table.
module tb_ov5640_dvp_pattern_tx;

  localparam int HA   = 8;
  localparam int VA   = 4;
  localparam int HB   = 4;
  localparam int VS   = 3;
  localparam int VB   = 2;
  localparam int VF   = 2;
  localparam int LINE = 2 * HA + HB;
  localparam int FP   = VS + VB + VA * LINE + VF;

  logic        cam_pclk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic        frame_start;
  logic [15:0] frame_cnt;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_fs  = 0;

  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic [15:0] cap [4][VA][HA];

  typedef struct {
    int          pat;
    int          x;
    int          y;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [18];

  ov5640_dvp_pattern_tx #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_W(VS), .V_BACK(VB), .V_FRONT(VF), .SOLID_RGB(16'hF800)
  ) dut (
    .cam_pclk(cam_pclk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .frame_start(frame_start), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 cam_pclk = ~cam_pclk;
  always @(posedge cam_pclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_pix(input int pat, input int x, input int y, input int fc);
    logic [15:0] p;
    case (pat)
      0:       p = 16'hF800;
      1:       p = bars[x / (HA / 8)];
      2:       p = 16'((x + y) & 32'hFFFF);
      default: p = ((((x >> 4) ^ (y >> 4)) & 1) != 0) ? 16'hFFFF : 16'h0000;
    endcase
`ifdef DVP_TX_FRAME_TAG_EN
    if (x == 0 && y == 0) p = 16'(fc);
`endif
    return p;
  endfunction

  // Waits for frame_start, then checks every cycle of one frame against the model.
  task automatic run_frame(input int pat, input int pat_next, input int drop_k, input int fc, input bit cont);
    int w, r, x, y, c;
    logic exp_vs, exp_hr;
    logic [7:0] exp_d;
    logic [15:0] p;
    w = 0;
    while (frame_start !== 1'b1 && w < 300) begin
      @(negedge cam_pclk);
      w++;
    end
    if (frame_start !== 1'b1) begin
      chk("frame_start timeout", 64'd0, 64'd1);
      return;
    end
    if (cont) chk("frame period", 64'(cyc - last_fs), 64'(FP));
    last_fs = cyc;
    pattern_sel = 2'(pat_next);
    for (int k = 0; k < FP; k++) begin
      exp_vs = (k < VS);
      exp_hr = 1'b0;
      exp_d  = 8'd0;
      x = 0; y = 0; c = 0;
      r = k - VS - VB;
      if (r >= 0 && r < VA * LINE) begin
        y = r / LINE;
        c = r % LINE;
        if (c < 2 * HA) begin
          exp_hr = 1'b1;
          x = c / 2;
          p = ref_pix(pat, x, y, fc);
          exp_d = (c % 2 == 1) ? p[7:0] : p[15:8];
          if (c % 2 == 1) cap[pat][y][x][7:0] = cam_data;
          else            cap[pat][y][x][15:8] = cam_data;
        end
      end
      chk($sformatf("cycle %0d of frame %0d", k, fc),
          {cam_vsync, cam_href, cam_data, frame_start, busy, frame_cnt},
          {exp_vs, exp_hr, exp_d, (k == 0), 1'b1, 16'(fc)});
      if (k == drop_k) enable = 1'b0;
      @(negedge cam_pclk);
    end
  endtask

  initial begin
    int cur, nxt, seen;
    vecs[0] = '{1, 0, 1, 16'hFFFF};  vecs[1] = '{1, 1, 1, 16'hFFE0};
    vecs[2] = '{1, 2, 1, 16'h07FF};  vecs[3] = '{1, 3, 1, 16'h07E0};
    vecs[4] = '{1, 4, 1, 16'hF81F};  vecs[5] = '{1, 5, 1, 16'hF800};
    vecs[6] = '{1, 6, 1, 16'h001F};  vecs[7] = '{1, 7, 1, 16'h0000};
    for (int i = 0; i < 8; i++) vecs[8 + i] = '{2, i, 3, 16'(3 + i)};
    vecs[16] = '{0, 5, 2, 16'hF800};
    vecs[17] = '{3, 3, 1, 16'h0000};

    rst_n = 1'b0; enable = 1'b0; pattern_sel = 2'd0;
    repeat (3) @(negedge cam_pclk);
    chk("reset outputs", {cam_vsync, cam_href, cam_data, frame_start, busy, frame_cnt}, 64'd0);

    enable = 1'b1;
    rst_n = 1'b1;
    @(negedge cam_pclk);
    chk("no start on first edge", {frame_start, busy}, 64'd0);

    // Frame 1: enable dropped mid-line 2, frame must still complete.
    run_frame(0, 1, VS + VB + 2 * LINE + 3, 1, 1'b0);
    chk("idle after drop", busy, 64'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (frame_start === 1'b1 || busy === 1'b1) seen++;
      @(negedge cam_pclk);
    end
    chk("quiet while disabled", 64'(seen), 64'd0);
    chk("frame_cnt after drop", frame_cnt, 64'd1);

    pattern_sel = 2'd1;
    enable = 1'b1;
    run_frame(1, 0, -1, 2, 1'b0);
    run_frame(0, 2, -1, 3, 1'b1);
    run_frame(2, 3, -1, 4, 1'b1);
    cur = 3;
    for (int f = 5; f < 13; f++) begin
      nxt = int'($urandom_range(0, 3));
      run_frame(cur, nxt, -1, f, 1'b1);
      cur = nxt;
    end

    foreach (vecs[i])
      chk($sformatf("table pat %0d pix(%0d,%0d)", vecs[i].pat, vecs[i].x, vecs[i].y),
          cap[vecs[i].pat][vecs[i].y][vecs[i].x], vecs[i].exp);

    // Asynchronous reset in the middle of an active line.
    seen = 0;
    while (frame_start !== 1'b1 && seen < 300) begin
      @(negedge cam_pclk);
      seen++;
    end
    repeat (VS + VB + 5) @(negedge cam_pclk);
    chk("href before reset", cam_href, 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("async reset clears", {cam_vsync, cam_href, cam_data, frame_start, busy, frame_cnt}, 64'd0);
    @(negedge cam_pclk);
    @(negedge cam_pclk);
    pattern_sel = 2'd2;
    rst_n = 1'b1;
    @(negedge cam_pclk);
    chk("no start on first edge after reset", {frame_start, busy}, 64'd0);
    run_frame(2, 2, -1, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
